// File: rtl/adder_settle_ctrl.sv
// adder_settle_ctrl: clocked wrapper around a 16-bit combinational adder.
// Launches an operand pair onto registered adder inputs, waits a programmable
// number of cycles for the ripple to settle, then registers sum, carry-out and
// signed overflow and offers them over a valid/ready handshake.
module adder_settle_ctrl #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  // upstream operand handshake
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  // attached combinational adder
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_ci,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_co,
  // downstream result handshake
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_co,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Counter starts at SETTLE_CYCLES-1 so capture lands SETTLE_CYCLES edges
  // after the accept edge (capture happens on the edge that sees cnt==0).
  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             add_ci_q, add_ci_d;
  logic [WIDTH-1:0] out_s_q, out_s_d;
  logic             out_co_q, out_co_d;
  logic             out_ovf_q, out_ovf_d;
  logic             ovf_now;

  // Ready only while idle and not being reset, so nothing slips in during reset.
  assign in_ready = (state_q == IDLE) && !rst;

  // Signed overflow: operands share a sign that the sum does not.
  assign ovf_now = (add_a_q[WIDTH-1] == add_b_q[WIDTH-1]) &&
                   (add_s[WIDTH-1]   != add_a_q[WIDTH-1]);

  // Next-state and datapath load decisions; every register holds by default.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_ci_d  = add_ci_q;
    out_s_d   = out_s_q;
    out_co_d  = out_co_q;
    out_ovf_d = out_ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          add_a_d  = in_a;
          add_b_d  = in_b;
          add_ci_d = in_ci;
          cnt_d    = CNT_LOAD;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          out_s_d   = add_s;
          out_co_d  = add_co;
          out_ovf_d = ovf_now;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_ci_q  <= 1'b0;
      out_s_q   <= '0;
      out_co_q  <= 1'b0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_ci_q  <= add_ci_d;
      out_s_q   <= out_s_d;
      out_co_q  <= out_co_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_ci    = add_ci_q;
  assign out_valid = (state_q == HOLD);
  assign out_s     = out_s_q;
  assign out_co    = out_co_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_adder_settle_ctrl.sv
// Directed bench for adder_settle_ctrl: one instance with SETTLE_CYCLES=4 and
// one with SETTLE_CYCLES=1, each driving a behavioural 16-bit adder.
module tb_adder_settle_ctrl;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Index 0: SETTLE_CYCLES=4 instance, index 1: SETTLE_CYCLES=1 instance.
  logic         rst       [2];
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [W-1:0] in_a      [2];
  logic [W-1:0] in_b      [2];
  logic         in_ci     [2];
  logic [W-1:0] add_a     [2];
  logic [W-1:0] add_b     [2];
  logic         add_ci    [2];
  logic [W-1:0] add_s     [2];
  logic         add_co    [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [W-1:0] out_s     [2];
  logic         out_co    [2];
  logic         out_ovf   [2];

  int sc [2];
  initial begin
    sc[0] = 4;
    sc[1] = 1;
  end

  adder_settle_ctrl #(.WIDTH(W), .SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_ci(in_ci[0]),
    .add_a(add_a[0]), .add_b(add_b[0]), .add_ci(add_ci[0]),
    .add_s(add_s[0]), .add_co(add_co[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_s(out_s[0]), .out_co(out_co[0]), .out_ovf(out_ovf[0])
  );

  adder_settle_ctrl #(.WIDTH(W), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .in_ci(in_ci[1]),
    .add_a(add_a[1]), .add_b(add_b[1]), .add_ci(add_ci[1]),
    .add_s(add_s[1]), .add_co(add_co[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_s(out_s[1]), .out_co(out_co[1]), .out_ovf(out_ovf[1])
  );

  // Behavioural adders attached to each instance.
  assign {add_co[0], add_s[0]} = {1'b0, add_a[0]} + {1'b0, add_b[0]} + {{W{1'b0}}, add_ci[0]};
  assign {add_co[1], add_s[1]} = {1'b0, add_a[1]} + {1'b0, add_b[1]} + {{W{1'b0}}, add_ci[1]};

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
    int           hold;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation on instance d and returns the cycle of its accept edge.
  task automatic run_op(input int d, input vec_t v, output int acc_cyc);
    int n;
    int k;
    acc_cyc     = -1;
    in_a[d]     = v.a;
    in_b[d]     = v.b;
    in_ci[d]    = v.ci;
    in_valid[d] = 1'b1;
    out_ready[d] = (v.hold == 0);
    n = 0;
    while (!in_ready[d] && n < 100) begin
      step();
      n++;
    end
    if (!in_ready[d]) begin
      chk("accept_timeout", 32'(in_ready[d]), 32'd1);
      in_valid[d] = 1'b0;
      return;
    end
    step();
    acc_cyc     = cyc;
    in_valid[d] = 1'b0;
    chk("launch_add_a", 32'(add_a[d]), 32'(v.a));
    chk("launch_add_b", 32'(add_b[d]), 32'(v.b));
    chk("launch_add_ci", 32'(add_ci[d]), 32'(v.ci));
    chk("busy_in_ready", 32'(in_ready[d]), 32'd0);
    k = 0;
    while (!out_valid[d] && k < 300) begin
      step();
      k++;
    end
    chk("latency", 32'(k), 32'(sc[d]));
    chk("out_s", 32'(out_s[d]), 32'(v.s));
    chk("out_co", 32'(out_co[d]), 32'(v.co));
    chk("out_ovf", 32'(out_ovf[d]), 32'(v.ovf));
    // Back-pressure: offer a stray operand that must be ignored.
    if (v.hold > 0) begin
      in_a[d]     = ~v.a;
      in_b[d]     = ~v.b;
      in_valid[d] = 1'b1;
    end
    for (int h = 0; h < v.hold; h++) begin
      step();
      chk("hold_valid", 32'(out_valid[d]), 32'd1);
      chk("hold_out_s", 32'(out_s[d]), 32'(v.s));
      chk("hold_flags", {30'd0, out_co[d], out_ovf[d]}, {30'd0, v.co, v.ovf});
      chk("hold_in_ready", 32'(in_ready[d]), 32'd0);
      chk("hold_add_a", 32'(add_a[d]), 32'(v.a));
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    step();
    chk("post_valid", 32'(out_valid[d]), 32'd0);
    chk("post_in_ready", 32'(in_ready[d]), 32'd1);
    chk("post_out_s", 32'(out_s[d]), 32'(v.s));
    $display("op dut%0d a=%04h b=%04h ci=%0d -> s=%04h co=%0d ovf=%0d latency=%0d accept_cyc=%0d",
             d, v.a, v.b, v.ci, out_s[d], out_co[d], out_ovf[d], k, acc_cyc);
  endtask

  vec_t vt [8];
  vec_t v1 [3];
  vec_t tmp;
  int   acc, prev_acc;
  bit   rose;

  initial begin
    //            a         b         ci    s         co    ovf   hold
    vt[0] = '{16'h6677, 16'h2233, 1'b0, 16'h88AA, 1'b0, 1'b1, 0};
    vt[1] = '{16'hABCD, 16'hF39C, 1'b0, 16'h9F69, 1'b1, 1'b0, 10};
    vt[2] = '{16'h8888, 16'h7777, 1'b0, 16'hFFFF, 1'b0, 1'b0, 0};
    vt[3] = '{16'h8888, 16'h7777, 1'b1, 16'h0000, 1'b1, 1'b0, 0};
    vt[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0};
    vt[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 3};
    vt[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 0};
    vt[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0};
    v1[0] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0, 0};
    v1[1] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 2};
    v1[2] = '{16'h1234, 16'h0F0F, 1'b1, 16'h2144, 1'b0, 1'b0, 0};

    for (int d = 0; d < 2; d++) begin
      rst[d]       = 1'b1;
      in_valid[d]  = 1'b0;
      in_a[d]      = '0;
      in_b[d]      = '0;
      in_ci[d]     = 1'b0;
      out_ready[d] = 1'b0;
    end

    // Reset: everything zero and not ready while rst is held.
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", 32'(in_ready[d]), 32'd0);
      chk("rst_out_valid", 32'(out_valid[d]), 32'd0);
      chk("rst_add", {add_a[d], add_b[d]}, 32'd0);
      chk("rst_add_ci", 32'(add_ci[d]), 32'd0);
      chk("rst_out", {13'd0, out_co[d], out_ovf[d], 1'b0, out_s[d]}, 32'd0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    step();
    chk("release_in_ready0", 32'(in_ready[0]), 32'd1);
    chk("release_in_ready1", 32'(in_ready[1]), 32'd1);

    // Table-driven operations on the SETTLE_CYCLES=4 instance.
    prev_acc = -1;
    for (int i = 0; i < 8; i++) begin
      run_op(0, vt[i], acc);
      if (i == 3) chk("accept_spacing", 32'(acc - prev_acc), 32'd6);
      prev_acc = acc;
    end

    // Reset mid-SETTLE: the operation is dropped, the next one completes.
    in_a[0]      = 16'h1234;
    in_b[0]      = 16'h1111;
    in_ci[0]     = 1'b0;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    step();                       // accept edge
    in_valid[0] = 1'b0;
    chk("midrst_launch", 32'(add_a[0]), 32'h1234);
    step();                       // cnt now 2
    rst[0] = 1'b1;
    chk("midrst_in_ready", 32'(in_ready[0]), 32'd0);
    step();
    chk("midrst_add_a", 32'(add_a[0]), 32'd0);
    chk("midrst_out_valid", 32'(out_valid[0]), 32'd0);
    rst[0] = 1'b0;
    rose = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (out_valid[0]) rose = 1'b1;
    end
    chk("midrst_no_valid", 32'(rose), 32'd0);
    chk("midrst_out_s", 32'(out_s[0]), 32'd0);
    $display("op dut0 reset mid-settle: add_a=%04h out_valid_seen=%0d", add_a[0], rose);
    tmp = '{16'h00FF, 16'h0101, 1'b0, 16'h0200, 1'b0, 1'b0, 0};
    run_op(0, tmp, acc);

    // SETTLE_CYCLES=1 instance.
    prev_acc = -1;
    for (int i = 0; i < 3; i++) begin
      run_op(1, v1[i], acc);
      if (i == 1) chk("accept_spacing_s1", 32'(acc - prev_acc), 32'd3);
      prev_acc = acc;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
